// File: rtl/tx_serial_arbitro.sv
// Round-robin arbiter that shares one serial transmitter among N requesters, with a watchdog on tx_pronto.
// req sampled in INICIAL gives tx_partida the next cycle; requesters hold req until their one-cycle ack.
module tx_serial_arbitro #(
   parameter int N       = 4,
   parameter int IW      = 2,
   parameter int TIMEOUT = 8192,
   parameter int TW      = 13
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [7*N-1:0]    dados,
   output logic [N-1:0]      ack,
   output logic              tx_partida,
   output logic [6:0]        tx_dados,
   input  logic              tx_pronto,
   output logic              ocupado,
   output logic              erro,
   output logic [IW-1:0]     grant,
   output logic [3:0]        db_estado
);

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      PARTIDA  = 4'd1,
      ESPERA   = 4'd2,
      CONFIRMA = 4'd3,
      ERRO     = 4'd4
   } estado_t;

   estado_t         state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [6:0]      tx_dados_q, tx_dados_d;
   logic [N-1:0]    ack_q, ack_d;
   logic            tx_partida_q, tx_partida_d;
   logic            ocupado_q, ocupado_d;
   logic            erro_q, erro_d;

   logic            found;
   int              idx;
   int              cand;
   logic [IW-1:0]   ptr_next;

   // Next pointer after a completed or abandoned grant: one past the winner, wrapping at N.
   assign ptr_next = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      timer_d    = timer_q;
      grant_d    = grant_q;
      tx_dados_d = tx_dados_q;
      erro_d     = erro_q;
      found      = 1'b0;
      idx        = 0;
      cand       = 0;

      for (int i = 0; i < N; i++) begin
         cand = (int'(ptr_q) + i) % N;
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end

      case (state_q)
         INICIAL: begin
            if (found) begin
               grant_d    = IW'(idx);
               tx_dados_d = dados[7*idx +: 7];
               state_d    = PARTIDA;
            end
         end
         PARTIDA: begin
            timer_d = '0;
            state_d = ESPERA;
         end
         ESPERA: begin
            timer_d = timer_q + 1'b1;
            // A ready pulse on the last watchdog cycle still completes the character.
            if (tx_pronto) begin
               state_d = CONFIRMA;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = ERRO;
            end
         end
         CONFIRMA: begin
            ptr_d   = ptr_next;
            state_d = INICIAL;
         end
         ERRO: begin
            ptr_d   = ptr_next;
            state_d = INICIAL;
         end
         default: state_d = INICIAL;
      endcase

      // Outputs are registered against the next state so they line up with db_estado.
      tx_partida_d = (state_d == PARTIDA);
      ocupado_d    = (state_d != INICIAL);
      ack_d        = '0;
      if (state_d == CONFIRMA) begin
         ack_d[grant_d] = 1'b1;
      end
      if (state_d == ERRO) begin
         erro_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= INICIAL;
         ptr_q        <= '0;
         timer_q      <= '0;
         grant_q      <= '0;
         tx_dados_q   <= '0;
         ack_q        <= '0;
         tx_partida_q <= 1'b0;
         ocupado_q    <= 1'b0;
         erro_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         timer_q      <= timer_d;
         grant_q      <= grant_d;
         tx_dados_q   <= tx_dados_d;
         ack_q        <= ack_d;
         tx_partida_q <= tx_partida_d;
         ocupado_q    <= ocupado_d;
         erro_q       <= erro_d;
      end
   end

   assign ack        = ack_q;
   assign tx_partida = tx_partida_q;
   assign tx_dados   = tx_dados_q;
   assign ocupado    = ocupado_q;
   assign erro       = erro_q;
   assign grant      = grant_q;
   assign db_estado  = state_q;

endmodule

// File: tb/tb_tx_serial_arbitro.sv
// Bench for tx_serial_arbitro: table of single transactions plus hand sequences for
// simultaneous requests, fairness, watchdog timeout, mid-transaction reset and same-cycle priority.
module tb_tx_serial_arbitro;

   localparam int N          = 4;
   localparam int IW         = 2;
   localparam int TIMEOUT    = 16;
   localparam int TW         = 5;
   localparam int PRONTO_DLY = 10;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic [7*N-1:0]    dados;
   logic [N-1:0]      ack;
   logic              tx_partida;
   logic [6:0]        tx_dados;
   logic              tx_pronto;
   logic              ocupado;
   logic              erro;
   logic [IW-1:0]     grant;
   logic [3:0]        db_estado;

   tx_serial_arbitro #(.N(N), .IW(IW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .dados      (dados),
      .ack        (ack),
      .tx_partida (tx_partida),
      .tx_dados   (tx_dados),
      .tx_pronto  (tx_pronto),
      .ocupado    (ocupado),
      .erro       (erro),
      .grant      (grant),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  req;
      logic [27:0] dados;
      logic [1:0]  exp_grant;
      logic [6:0]  exp_char;
   } vec_t;

   typedef struct {
      logic [1:0] g;
      logic [6:0] c;
   } exp_t;

   vec_t vec[7];
   exp_t exp_q[$];

   int   checks   = 0;
   int   failures = 0;
   int   cnt      = 0;
   bit   pronto_en = 1'b1;
   bit   auto_drop = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: sample just after the edge, run the transmitter model and the ack scoreboard.
   task automatic step();
      exp_t e;
      @(posedge clock);
      #1;
      tx_pronto = 1'b0;
      if (pronto_en) begin
         if (tx_partida) begin
            cnt = PRONTO_DLY;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) tx_pronto = 1'b1;
         end
      end
      if (ack != '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ack_onehot", 32'(ack), 32'(4'(4'b0001 << e.g)));
            chk("ack_grant", 32'(grant), 32'(e.g));
            chk("ack_tx_dados", 32'(tx_dados), 32'(e.c));
            chk("ack_db_estado", 32'(db_estado), 32'd3);
         end
         if (auto_drop) req = req & ~ack;
      end
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("wait_empty_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      vec[0] = '{4'b0100, {7'h30, 7'h41, 7'h31, 7'h32}, 2'd2, 7'h41};
      vec[1] = '{4'b0001, {7'h33, 7'h34, 7'h35, 7'h55}, 2'd0, 7'h55};
      vec[2] = '{4'b1001, {7'h5A, 7'h36, 7'h37, 7'h38}, 2'd3, 7'h5A};
      vec[3] = '{4'b1001, {7'h39, 7'h3A, 7'h3B, 7'h61}, 2'd0, 7'h61};
      vec[4] = '{4'b0110, {7'h3C, 7'h3D, 7'h62, 7'h3E}, 2'd1, 7'h62};
      vec[5] = '{4'b1010, {7'h63, 7'h3F, 7'h40, 7'h42}, 2'd3, 7'h63};
      vec[6] = '{4'b1000, {7'h64, 7'h43, 7'h44, 7'h45}, 2'd3, 7'h64};

      reset = 1'b1; req = '0; dados = '0; tx_pronto = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_db_estado", 32'(db_estado), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_partida", 32'(tx_partida), 32'd0);
      chk("rst_tx_dados", 32'(tx_dados), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_erro", 32'(erro), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      step();
      chk("idle_db_estado", 32'(db_estado), 32'd0);

      // Table-driven single transactions; the rotating pointer makes the multi-bit rows meaningful.
      for (int k = 0; k < 7; k++) begin
         dados = vec[k].dados;
         req   = vec[k].req;
         exp_q.push_back('{vec[k].exp_grant, vec[k].exp_char});
         step();
         chk("vec_partida", 32'(tx_partida), 32'd1);
         chk("vec_ocupado", 32'(ocupado), 32'd1);
         chk("vec_tx_dados", 32'(tx_dados), 32'(vec[k].exp_char));
         chk("vec_grant", 32'(grant), 32'(vec[k].exp_grant));
         step();
         chk("vec_partida_one_cycle", 32'(tx_partida), 32'd0);
         chk("vec_db_espera", 32'(db_estado), 32'd2);
         wait_empty(60);
         step();
         chk("vec_ack_one_cycle", 32'(ack), 32'd0);
         chk("vec_ocupado_after", 32'(ocupado), 32'd0);
         chk("vec_db_after", 32'(db_estado), 32'd0);
         chk("vec_erro", 32'(erro), 32'd0);
      end

      // Simultaneous requests: service order 0,1,2,3, one ack each.
      dados = {7'h4B, 7'h4A, 7'h49, 7'h48};
      req   = 4'b1111;
      exp_q.push_back('{2'd0, 7'h48});
      exp_q.push_back('{2'd1, 7'h49});
      exp_q.push_back('{2'd2, 7'h4A});
      exp_q.push_back('{2'd3, 7'h4B});
      wait_empty(200);
      for (int i = 0; i < 20; i++) step();
      chk("simul_req_cleared", 32'(req), 32'd0);
      chk("simul_idle", 32'(db_estado), 32'd0);

      // Fairness: req0 and req3 held continuously.
      auto_drop = 1'b0;
      dados = {7'h52, 7'h51, 7'h50, 7'h4F};
      req   = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{2'd0, 7'h4F});
         exp_q.push_back('{2'd3, 7'h52});
      end
      wait_empty(300);
      req = '0;
      auto_drop = 1'b1;
      step();
      chk("fair_idle", 32'(db_estado), 32'd0);

      // Watchdog timeout on requester 1; pointer then moves on to 2.
      pronto_en = 1'b0;
      dados = {7'h30, 7'h31, 7'h46, 7'h32};
      req   = 4'b0010;
      step();
      chk("to_partida", 32'(tx_partida), 32'd1);
      chk("to_grant", 32'(grant), 32'd1);
      step();
      n = 0;
      while (db_estado == 4'd2 && n < 40) begin
         n++;
         step();
      end
      chk("to_espera_cycles", 32'(n), 32'd16);
      chk("to_db_erro", 32'(db_estado), 32'd4);
      chk("to_erro_flag", 32'(erro), 32'd1);
      chk("to_no_ack", 32'(ack), 32'd0);
      req = '0;
      step();
      chk("to_back_inicial", 32'(db_estado), 32'd0);
      chk("to_erro_sticky", 32'(erro), 32'd1);
      chk("to_ocupado", 32'(ocupado), 32'd0);
      pronto_en = 1'b1;
      dados = {7'h30, 7'h47, 7'h31, 7'h32};
      req   = 4'b0110;
      exp_q.push_back('{2'd2, 7'h47});
      wait_empty(60);
      req = '0;
      step();
      chk("to_erro_still", 32'(erro), 32'd1);

      // Reset in the middle of ESPERA clears everything, including the pointer.
      dados = {7'h30, 7'h4C, 7'h31, 7'h32};
      req   = 4'b0100;
      step(); step(); step();
      chk("mr_in_espera", 32'(db_estado), 32'd2);
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
      cnt   = 0;
      chk("mr_db", 32'(db_estado), 32'd0);
      chk("mr_ocupado", 32'(ocupado), 32'd0);
      chk("mr_grant", 32'(grant), 32'd0);
      chk("mr_tx_dados", 32'(tx_dados), 32'd0);
      chk("mr_erro", 32'(erro), 32'd0);
      chk("mr_ack", 32'(ack), 32'd0);
      chk("mr_partida", 32'(tx_partida), 32'd0);
      dados = {7'h4E, 7'h31, 7'h32, 7'h4D};
      req   = 4'b1001;
      exp_q.push_back('{2'd0, 7'h4D});
      wait_empty(60);
      req = 4'b1000;
      step();
      exp_q.push_back('{2'd3, 7'h4E});
      wait_empty(60);
      step();

      // Spurious pronto in INICIAL, then pronto on the last watchdog cycle with dados churning.
      pronto_en = 1'b0;
      tx_pronto = 1'b1;
      dados = 28'($urandom);
      step();
      chk("st_idle_pronto_db", 32'(db_estado), 32'd0);
      chk("st_idle_pronto_ocupado", 32'(ocupado), 32'd0);
      dados = {7'h30, 7'h58, 7'h31, 7'h32};
      req   = 4'b0100;
      tx_pronto = 1'b1;
      step();
      chk("st_partida_db", 32'(db_estado), 32'd1);
      chk("st_tx_dados", 32'(tx_dados), 32'h58);
      step();
      n = 0;
      while (db_estado == 4'd2 && n < 40) begin
         n++;
         chk("st_hold_tx_dados", 32'(tx_dados), 32'h58);
         chk("st_hold_grant", 32'(grant), 32'd2);
         dados = 28'($urandom);
         req   = 4'($urandom) | 4'b0100;
         if (n == 16) begin
            tx_pronto = 1'b1;
            exp_q.push_back('{2'd2, 7'h58});
         end
         step();
      end
      req = '0;
      chk("st_espera_cycles", 32'(n), 32'd16);
      chk("st_confirma_db", 32'(db_estado), 32'd3);
      chk("st_no_erro", 32'(erro), 32'd0);
      chk("st_queue_drained", 32'(exp_q.size()), 32'd0);
      step();
      chk("st_final_ocupado", 32'(ocupado), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tx_serial_arbitro.md
Name: tx_serial_arbitro

Overview:
- Round-robin arbiter and sequencer that shares one 7O1 serial transmitter among N requesters.
- Each requester presents a 7-bit ASCII character and a request. The block picks a winner, latches its character and issues a one-cycle start pulse to the transmitter.
- It then waits for the transmitter's ready pulse and acknowledges the winner.
- It sits between application logic (message generators, debug reporters) and the transmitter's partida/dados_ascii/pronto interface, and adds a watchdog timeout.

Parameters:
- N, 4, number of requesters.
- IW, 2, width of the grant index; 2^IW >= N.
- TIMEOUT, 8192, maximum cycles waited in ESPERA for tx_pronto. One 7O1 character at 434 clocks/bit is about 4340 cycles.
- TW, 13, width of the watchdog counter; 2^TW >= TIMEOUT.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per requester; hold high until ack.
- dados  input  7*N  character per requester; requester i uses bits [7i+6:7i].
- ack  output  N  one-cycle pulse: the granted requester's character was transmitted.
- tx_partida  output  1  start pulse to the transmitter.
- tx_dados  output  7  character to the transmitter; registered.
- tx_pronto  input  1  transmitter ready pulse, end of character.
- ocupado  output  1  high while a transaction is in progress.
- erro  output  1  sticky flag: a watchdog timeout occurred.
- grant  output  IW  index of the requester currently or last served.
- db_estado  output  4  state code for a hex display.

Behaviour:
- Reset (synchronous, active-high) takes effect on the next edge:
  - state = INICIAL; rotating priority pointer ptr = 0; watchdog timer = 0.
  - ack = 0, tx_partida = 0, tx_dados = 0, ocupado = 0, erro = 0, grant = 0, db_estado = 0.
  - Reset overrides everything, including mid-transaction. A transmission already started in the transmitter is not aborted by this block.
- All outputs are registered.
- State codes for db_estado: INICIAL=0, PARTIDA=1, ESPERA=2, CONFIRMA=3, ERRO=4.
- INICIAL:
  - If req == 0, stay.
  - Otherwise select the first asserted req searching ptr, ptr+1, ..., wrapping modulo N.
  - Register grant = winner and tx_dados = dados slice of the winner, then go to PARTIDA.
  - tx_pronto is ignored in this state.
- PARTIDA:
  - tx_partida = 1 for exactly this one cycle; ocupado = 1; timer cleared.
  - Next state ESPERA.
  - Latency: req sampled at edge t gives tx_partida high in cycle t+1.
- ESPERA:
  - Timer increments each cycle.
  - If tx_pronto = 1, go to CONFIRMA. tx_pronto has priority over timeout in the same cycle.
  - Else if timer == TIMEOUT-1, go to ERRO.
- CONFIRMA:
  - ack[grant] = 1 for one cycle; all other ack bits stay 0.
  - ptr = grant+1 modulo N. Next state INICIAL; ocupado drops in INICIAL.
- ERRO:
  - erro set to 1 and held until reset; no ack is issued.
  - ptr = grant+1 modulo N. Next state INICIAL.
- tx_dados and grant hold stable from INICIAL exit until the next arbitration. Changes on dados or req during a transaction are ignored.
- A winner that drops req mid-transaction is still completed and acked.
- Requester contract: deassert req (registered) in the cycle after ack. The INICIAL cycle following CONFIRMA then samples the updated req, so no duplicate send occurs.
- Each transaction takes at least 4 cycles (INICIAL, PARTIDA, ESPERA, CONFIRMA). Back-to-back service needs no idle cycles beyond INICIAL.
- The edge detector inside the transmitter converts tx_partida; the single-cycle width guarantees one start per grant.

Test Plan:
- Single request: reset, then req=4'b0100 with dados slice 2 = 7'h41; a transmitter model pulses tx_pronto 10 cycles after tx_partida. Required: tx_partida high one cycle at t+1, tx_dados=7'h41, grant=2, ack=4'b0100 one cycle, ocupado low afterwards, erro=0.
- Simultaneous requests: all four req high after reset with distinct characters; each requester drops req after its ack. Required: service order 0,1,2,3; exactly one ack per requester; tx_dados sequence matches.
- Fairness: req0 and req3 re-asserted continuously. Required: grants alternate 0,3,0,3 for at least 6 transactions.
- Timeout with TIMEOUT=16: req1 high, tx_pronto never asserted. Required: ERRO state (db_estado=4) at cycle 16 after entering ESPERA, erro=1 sticky, no ack; a following req2 is served normally and erro stays 1.
- Reset mid-ESPERA: assert reset for one cycle. Required: next cycle state INICIAL, all outputs 0, ptr=0; a subsequent req3 is granted.
- Stability and priority: change dados and pulse tx_pronto while in INICIAL; in ESPERA present tx_pronto in the same cycle timer==TIMEOUT-1. Required: tx_dados unchanged during the transaction, spurious pronto ignored, CONFIRMA taken (not ERRO).
